bus_transfer_ctrl: RTL

Register-transfer sequencer on the driving side of the shared data bus. Holds a small register bank and, on command, places one source register onto BUS for two cycles, then loads the bus value into a destination register. Its BUS output feeds the BUS input of the per-register 2:1 load muxes elsewhere in the datapath. It also accepts direct external loads on DA.

---
 rtl/bus_xfer_pkg.sv | 18 +
 rtl/bus_transfer_ctrl_reg_bank.sv | 41 ++++
 rtl/bus_transfer_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/bus_xfer_pkg.sv
// Shared types and constants for the bus transfer sequencer and its register bank.
package bus_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LOAD  = 2'd2,
    DONE  = 2'd3
  } xfer_state_t;

  localparam int BUS_IDLE_VALUE = 0;

  // Index width for a bank of n registers; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_transfer_ctrl_reg_bank.sv
// Register bank with one prioritized write port and two combinational read ports.
module reg_bank
  import bus_xfer_pkg::*;
#(
  parameter  int WORD_LENGTH = 8,
  parameter  int NUM_REGS    = 4,
  localparam int IDX_W       = idx_width(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   xfer_we_i,
  input  logic [IDX_W-1:0]       xfer_idx_i,
  input  logic [WORD_LENGTH-1:0] xfer_data_i,
  input  logic                   ext_we_i,
  input  logic [IDX_W-1:0]       ext_idx_i,
  input  logic [WORD_LENGTH-1:0] ext_data_i,
  input  logic [IDX_W-1:0]       src_idx_i,
  output logic [WORD_LENGTH-1:0] src_data_o,
  input  logic [IDX_W-1:0]       rd_idx_i,
  output logic [WORD_LENGTH-1:0] rd_data_o
);

  logic [WORD_LENGTH-1:0] regs_q [NUM_REGS];

  // The controller never raises both enables together; transfer wins if it ever did.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (xfer_we_i) begin
      regs_q[xfer_idx_i] <= xfer_data_i;
    end else if (ext_we_i) begin
      regs_q[ext_idx_i] <= ext_data_i;
    end
  end

  assign src_data_o = regs_q[src_idx_i];
  assign rd_data_o  = regs_q[rd_idx_i];

endmodule

// File: rtl/bus_transfer_ctrl.sv
// Bus-driving transfer sequencer: drives a source register onto BUS for two cycles,
// then writes the bus value into the captured destination register.
module bus_transfer_ctrl
  import bus_xfer_pkg::*;
#(
  parameter  int WORD_LENGTH = 8,
  parameter  int NUM_REGS    = 4,
  localparam int IDX_W       = idx_width(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WORD_LENGTH-1:0] DA,
  input  logic                   Load_Ext,
  input  logic [IDX_W-1:0]       Ext_Dst,
  input  logic                   Xfer_Req,
  input  logic [IDX_W-1:0]       Xfer_Src,
  input  logic [IDX_W-1:0]       Xfer_Dst,
  output logic                   Busy,
  output logic                   Done,
  output logic [WORD_LENGTH-1:0] BUS,
  output logic                   Bus_En,
  input  logic [IDX_W-1:0]       Rd_Sel,
  output logic [WORD_LENGTH-1:0] Rd_Data,
  output logic [1:0]             dbg_state_o
);

  // Handshake: Xfer_Req acts as valid and !Busy as ready; a request is accepted
  // on any rising edge where both are high, and Done pulses once per accepted request.

  xfer_state_t            state_q, state_d;
  logic [IDX_W-1:0]       dst_q, dst_d;
  logic [WORD_LENGTH-1:0] bus_q, bus_d;
  logic                   bus_en_q, bus_en_d;
  logic                   done_q, done_d;
  logic                   xfer_we, ext_we;
  logic [WORD_LENGTH-1:0] src_data;

  reg_bank #(
    .WORD_LENGTH(WORD_LENGTH),
    .NUM_REGS   (NUM_REGS)
  ) u_reg_bank (
    .clk        (clk),
    .reset      (reset),
    .xfer_we_i  (xfer_we),
    .xfer_idx_i (dst_q),
    .xfer_data_i(bus_q),
    .ext_we_i   (ext_we),
    .ext_idx_i  (Ext_Dst),
    .ext_data_i (DA),
    .src_idx_i  (Xfer_Src),
    .src_data_o (src_data),
    .rd_idx_i   (Rd_Sel),
    .rd_data_o  (Rd_Data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      dst_q    <= '0;
      bus_q    <= WORD_LENGTH'(BUS_IDLE_VALUE);
      bus_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dst_q    <= dst_d;
      bus_q    <= bus_d;
      bus_en_q <= bus_en_d;
      done_q   <= done_d;
    end
  end

  // The source value itself is captured into bus_q at acceptance, so only the
  // destination index needs its own holding register.
  always_comb begin
    state_d  = state_q;
    dst_d    = dst_q;
    bus_d    = bus_q;
    bus_en_d = bus_en_q;
    done_d   = 1'b0;
    xfer_we  = 1'b0;
    ext_we   = 1'b0;
    case (state_q)
      IDLE: begin
        ext_we = Load_Ext;
        if (Xfer_Req) begin
          dst_d    = Xfer_Dst;
          bus_d    = src_data;
          bus_en_d = 1'b1;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        state_d = LOAD;
      end
      LOAD: begin
        xfer_we  = 1'b1;
        bus_d    = WORD_LENGTH'(BUS_IDLE_VALUE);
        bus_en_d = 1'b0;
        done_d   = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Busy        = (state_q != IDLE);
  assign Done        = done_q;
  assign BUS         = bus_q;
  assign Bus_En      = bus_en_q;
  assign dbg_state_o = state_q;

endmodule
